// File: rtl/trace_drain_pkg.sv
// Shared definitions for the trace drain: frame marker, FSM states and
// the payload word-count helper.
package trace_drain_pkg;

  localparam logic [7:0] SYNC_MARKER = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    CAPTURE,
    HDR,
    PAY
  } drain_state_t;

  // Payload words needed to carry one trace element (ceiling division).
  function automatic int calc_n_words(input int trace_w, input int word_w);
    return (trace_w + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/trace_word_serialiser.sv
// Holds one captured trace element and presents it least-significant word
// first, with a word counter that flags the final payload word.
module trace_word_serialiser
  import trace_drain_pkg::*;
#(
  parameter int TRACE_WIDTH = 64,
  parameter int WORD_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   clear,
  input  logic                   shift,
  input  logic [TRACE_WIDTH-1:0] din,
  output logic [WORD_WIDTH-1:0]  word,
  output logic                   last
);

  localparam int N_WORDS = calc_n_words(TRACE_WIDTH, WORD_WIDTH);
  localparam int SR_W    = N_WORDS * WORD_WIDTH;
  localparam int CNT_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_WORDS - 1);

  logic [SR_W-1:0]  sr;
  logic [CNT_W-1:0] cnt;

  // Load zero-padded element, shift out one word per accepted payload beat.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sr  <= '0;
      cnt <= '0;
    end else begin
      if (load) begin
        sr <= SR_W'(din);
      end else if (shift) begin
        sr <= sr >> WORD_WIDTH;
      end
      if (clear) begin
        cnt <= '0;
      end else if (shift && !last) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign word = sr[WORD_WIDTH-1:0];
  assign last = (cnt == LAST_IDX);

endmodule

// File: rtl/trace_drain.sv
// Reader-side companion to the trace buffer: pops one element at a time
// and streams it as a header word plus payload words on valid/ready.
module trace_drain
  import trace_drain_pkg::*;
#(
  parameter type trace_output = int,
  parameter int  TRACE_WIDTH  = $bits(trace_output),
  parameter int  WORD_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   data_present,
  input  logic [TRACE_WIDTH-1:0] trace_element_in,
  output logic                   data_request,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_WIDTH-1:0]  out_data,
  output logic                   out_last,
  output logic                   busy
);

  localparam int SEQ_W = WORD_WIDTH - 8;

  drain_state_t          state;
  logic [SEQ_W-1:0]      seq;
  logic [WORD_WIDTH-1:0] pay_word;
  logic                  pay_last;
  logic                  load;
  logic                  hdr_fire;
  logic                  pay_fire;

  assign load     = (state == CAPTURE);
  assign hdr_fire = (state == HDR) && out_ready;
  assign pay_fire = (state == PAY) && out_ready;

  trace_word_serialiser #(
    .TRACE_WIDTH (TRACE_WIDTH),
    .WORD_WIDTH  (WORD_WIDTH)
  ) u_ser (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .clear (hdr_fire),
    .shift (pay_fire),
    .din   (trace_element_in),
    .word  (pay_word),
    .last  (pay_last)
  );

  // Frame sequencer: pop, capture, header, payload; control outputs registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      data_request <= 1'b0;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
      seq          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && data_present) begin
            state        <= REQ;
            data_request <= 1'b1;
            busy         <= 1'b1;
          end
        end
        REQ: begin
          state        <= CAPTURE;
          data_request <= 1'b0;
        end
        CAPTURE: begin
          state     <= HDR;
          out_valid <= 1'b1;
        end
        HDR: begin
          if (out_ready) begin
            state <= PAY;
          end
        end
        PAY: begin
          if (out_ready && pay_last) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            seq       <= seq + SEQ_W'(1);
          end
        end
        default: begin
          state        <= IDLE;
          data_request <= 1'b0;
          out_valid    <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

  // Word mux: header in HDR, serialiser low word in PAY, zero otherwise.
  always_comb begin
    out_data = '0;
    out_last = 1'b0;
    case (state)
      HDR: out_data = {SYNC_MARKER, seq};
      PAY: begin
        out_data = pay_word;
        out_last = pay_last;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/trace_drain.md
Name: trace_drain

Overview:
- Reader-side companion to the trace buffer.
- Polls the buffer's data_present, issues single-cycle data_request pulses and captures trace_element_out.
- Emits each captured element as a framed sequence of WORD_WIDTH words on a valid/ready stream toward the off-chip debug link: one header word, then the payload words.
- Sits between the trace buffer and the debug transport.

Parameters:
- trace_output, int: element type; must match the connected trace buffer.
- TRACE_WIDTH, $bits(trace_output): element width in bits.
- WORD_WIDTH, 32: output word width in bits; must be at least 16.
- N_WORDS, ceil(TRACE_WIDTH/WORD_WIDTH): payload words per frame; derived, never overridden.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-low reset.
- enable  input  1  permits starting new frames.
- data_present  input  1  buffer non-empty flag.
- trace_element_in  input  TRACE_WIDTH  buffer's trace_element_out.
- data_request  output  1  pop pulse to buffer.
- out_valid  output  1  out_data valid.
- out_ready  input  1  sink accepts word when high with out_valid.
- out_data  output  WORD_WIDTH  framed output word.
- out_last  output  1  marks the final payload word of a frame.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: rst low at posedge forces IDLE.
  - Outputs: data_request=0, out_valid=0, out_last=0, out_data=0, busy=0.
  - Internal state: seq=0, shift register=0.
  - Reset mid-frame drops the partial frame. The element already popped is lost; this is accepted.
- FSM states: IDLE, REQ, CAPTURE, HDR, PAY.
- IDLE: if enable && data_present, go to REQ.
- REQ: data_request=1 for exactly this cycle, then go to CAPTURE.
- CAPTURE: data_request=0. At the closing edge, register trace_element_in into the shift register, zero-padded to N_WORDS*WORD_WIDTH. Go to HDR.
- HDR:
  - out_valid=1.
  - out_data = {8'hA5, seq[WORD_WIDTH-9:0]} with the marker in the top byte.
  - On out_valid && out_ready: go to PAY and clear the word counter.
- PAY:
  - out_valid=1; out_data = shift register low word, least-significant word first.
  - out_last=1 when word counter == N_WORDS-1.
  - On handshake: shift right by WORD_WIDTH and increment the counter.
  - On the last-word handshake: seq += 1 (wraps modulo 2^(WORD_WIDTH-8)), go to IDLE.
- Handshake rules:
  - out_data and out_last are held stable while out_valid && !out_ready.
  - out_valid never drops without a handshake, except on reset.
- Latency: data_present sampled high in IDLE gives out_valid high 3 cycles later (REQ, CAPTURE, HDR).
- Throughput: with out_ready tied high, one frame per N_WORDS+4 cycles.
- Between pulses, data_request is low for at least N_WORDS+3 cycles. This gives the buffer's asynchronous pop time to settle.
- enable low mid-frame: the current frame completes, and no new REQ is issued until enable returns high.
- data_present falling while in REQ or CAPTURE: ignored; capture proceeds, because the pop was already committed.
- Empty buffer: stay in IDLE with data_request=0.
- out_ready high outside HDR/PAY: no effect.

Decomposition:
- Package trace_drain_pkg holds:
  - SYNC_MARKER = 8'hA5.
  - State enum drain_state_t {IDLE, REQ, CAPTURE, HDR, PAY}.
  - Function computing N_WORDS from the widths.
- One sub-module, trace_word_serialiser:
  - load / shift / word-counter datapath.
  - Outputs the low word and a last flag.
  - Parameterised by TRACE_WIDTH and WORD_WIDTH.
- The FSM stays in trace_drain.

Test Plan:
- Reset, single element, no backpressure:
  - Setup: after reset, data_present=1, enable=1, out_ready=1, TRACE_WIDTH=64, element 64'h1122334455667788.
  - Required: exactly one data_request pulse; words 32'hA5000000, 32'h55667788, 32'h11223344; out_last high only on the third word; busy low afterwards.
- Backpressure: same element, out_ready low for 5 cycles during HDR and 3 cycles during the second payload word -> out_data stable throughout, the same three words are delivered, and there are no duplicates.
- Sequence wrap: WORD_WIDTH=16, preload seq via 256 frames -> 257th frame header is 16'hA500.
- Enable gating: enable drops during PAY of frame 1 with data_present still high -> frame 1 completes, no data_request while enable is low, next REQ one cycle after enable rises.
- Reset mid-frame: rst low during PAY word 0 -> next cycle out_valid=0 and busy=0; first header after reset has seq=0.
- Non-multiple width: TRACE_WIDTH=40, WORD_WIDTH=32, element 40'hAB_CDEF0123 -> payload words 32'hCDEF0123 then 32'h000000AB.
